water_alarm_ctrl: RTL

WATER_ALARM_CTRL -- requirements
Module: water_alarm_ctrl

---
 rtl/water_pkg.sv | 44 ++++
 rtl/wl_debounce.sv | 69 ++++++
 rtl/water_alarm_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/water_pkg.sv
// Shared types for the water-level alarm controller.
// Holds level/state enums, legal indicator codes and the code decoder.
package water_pkg;

    typedef enum logic [1:0] {
        LVL_NORMAL = 2'd0,
        LVL_LOW    = 2'd1,
        LVL_MID    = 2'd2,
        LVL_HIGH   = 2'd3
    } level_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_ALARM   = 2'd2,
        ST_ACKED   = 2'd3
    } state_t;

    localparam logic [2:0] CODE_NORMAL = 3'b000;
    localparam logic [2:0] CODE_LOW    = 3'b001;
    localparam logic [2:0] CODE_MID    = 3'b011;
    localparam logic [2:0] CODE_HIGH   = 3'b100;

    typedef struct packed {
        logic   fault;
        level_t level;
    } dec_t;

    // Illegal indicator codes fail safe to HIGH and flag a fault.
    function automatic dec_t decode(input logic [2:0] code);
        dec_t d;
        d.fault = 1'b0;
        d.level = LVL_HIGH;
        case (code)
            CODE_NORMAL: d.level = LVL_NORMAL;
            CODE_LOW:    d.level = LVL_LOW;
            CODE_MID:    d.level = LVL_MID;
            CODE_HIGH:   d.level = LVL_HIGH;
            default:     d.fault = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wl_debounce.sv
// Tick-sampled debouncer for the decoded water-level code.
// Ports: clk, reset, clear, tick, raw in; level, fault, level_nxt out.
module wl_debounce
    import water_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic [2:0] raw,
    output level_t     level,
    output logic       fault,
    output level_t     level_nxt
);

    localparam logic [3:0] DB = 4'(DEBOUNCE_TICKS);

    dec_t       dec;
    dec_t       cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] run;
    level_t     lvl_q, lvl_d;
    logic       flt_q, flt_d;

    always_comb begin
        dec    = decode(raw);
        cand_d = cand_q;
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        flt_d  = flt_q;
        run    = 4'd1;
        if (tick) begin
            if (dec == cand_q) begin
                run = cnt_q + 4'd1;
            end
            cand_d = dec;
            // Count reloads to 0 on acceptance; a still-stable code just
            // re-accepts the same value every DEBOUNCE_TICKS ticks.
            if (run == DB) begin
                lvl_d = dec.level;
                flt_d = dec.fault;
                cnt_d = 4'd0;
            end else begin
                cnt_d = run;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cand_q <= '{fault: 1'b0, level: LVL_NORMAL};
            cnt_q  <= 4'd0;
            lvl_q  <= LVL_NORMAL;
            flt_q  <= 1'b0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            flt_q  <= flt_d;
        end
    end

    assign level     = lvl_q;
    assign fault     = flt_q;
    assign level_nxt = clear ? LVL_NORMAL : lvl_d;

endmodule

// File: rtl/water_alarm_ctrl.sv
// Water-level alarm controller: debounce, alarm FSM, blink and pump timers.
// Ports: clk, reset, en, warn_led, tick, ack in; level_code, buzzer,
// blink_led, pump_on, alarm_latched, fault out.
module water_alarm_ctrl
    import water_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS  = 4,
    parameter int unsigned BLINK_TICKS     = 8,
    parameter int unsigned PUMP_HOLD_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] warn_led,
    input  logic       tick,
    input  logic       ack,
    output logic [1:0] level_code,
    output logic       buzzer,
    output logic       blink_led,
    output logic       pump_on,
    output logic       alarm_latched,
    output logic       fault
);

    localparam logic [7:0] BL_LAST = 8'(BLINK_TICKS - 1);
    localparam logic [7:0] PH_LAST = 8'(PUMP_HOLD_TICKS - 1);

    level_t     lvl;
    level_t     lvl_nxt;
    logic       flt;

    state_t     state_q, state_d;
    logic       buz_q, buz_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic       entry_q, entry_d;
    logic       blink_q, blink_d;
    logic [7:0] lcnt_q, lcnt_d;
    logic       hold_q, hold_d;
    logic [7:0] hcnt_q, hcnt_d;

    wl_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_deb (
        .clk      (clk),
        .reset    (reset),
        .clear    (~en),
        .tick     (tick),
        .raw      (warn_led),
        .level    (lvl),
        .fault    (flt),
        .level_nxt(lvl_nxt)
    );

    always_comb begin
        state_d = state_q;
        buz_d   = buz_q;
        bcnt_d  = bcnt_q;
        entry_d = entry_q;
        blink_d = blink_q;
        lcnt_d  = lcnt_q;
        hold_d  = hold_q;
        hcnt_d  = hcnt_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_MONITOR;
            end
            ST_MONITOR: begin
                // Uses the incoming level so the alarm latches on the
                // same edge level_code turns HIGH.
                if (lvl_nxt == LVL_HIGH) begin
                    state_d = ST_ALARM;
                    buz_d   = 1'b1;
                    bcnt_d  = 8'd0;
                    entry_d = 1'b1;
                end
            end
            ST_ALARM: begin
                entry_d = 1'b0;
                // First ALARM cycle ignores ack.
                if (ack && !entry_q) begin
                    state_d = ST_ACKED;
                    buz_d   = 1'b0;
                    bcnt_d  = 8'd0;
                end else if (tick) begin
                    if (bcnt_q == BL_LAST) begin
                        bcnt_d = 8'd0;
                        buz_d  = ~buz_q;
                    end else begin
                        bcnt_d = bcnt_q + 8'd1;
                    end
                end
            end
            ST_ACKED: begin
                if (lvl_nxt != LVL_HIGH) begin
                    state_d = ST_MONITOR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Blink phase restarts lit each time the level enters MID.
        if (lvl != LVL_MID) begin
            blink_d = 1'b1;
            lcnt_d  = 8'd0;
        end else if (tick) begin
            if (lcnt_q == BL_LAST) begin
                lcnt_d  = 8'd0;
                blink_d = ~blink_q;
            end else begin
                lcnt_d = lcnt_q + 8'd1;
            end
        end

        // Hold stays armed while at or above MID; counts down after.
        if (lvl[1]) begin
            hold_d = 1'b1;
            hcnt_d = 8'd0;
        end else if (hold_q && tick) begin
            if (hcnt_q == PH_LAST) begin
                hold_d = 1'b0;
                hcnt_d = 8'd0;
            end else begin
                hcnt_d = hcnt_q + 8'd1;
            end
        end

        if (!en) begin
            state_d = ST_IDLE;
            buz_d   = 1'b0;
            bcnt_d  = 8'd0;
            entry_d = 1'b0;
            blink_d = 1'b1;
            lcnt_d  = 8'd0;
            hold_d  = 1'b0;
            hcnt_d  = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            buz_q   <= 1'b0;
            bcnt_q  <= 8'd0;
            entry_q <= 1'b0;
            blink_q <= 1'b1;
            lcnt_q  <= 8'd0;
            hold_q  <= 1'b0;
            hcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            buz_q   <= buz_d;
            bcnt_q  <= bcnt_d;
            entry_q <= entry_d;
            blink_q <= blink_d;
            lcnt_q  <= lcnt_d;
            hold_q  <= hold_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign level_code    = lvl;
    assign fault         = flt;
    assign buzzer        = buz_q && (state_q == ST_ALARM);
    assign blink_led     = (lvl == LVL_HIGH) || ((lvl == LVL_MID) && blink_q);
    assign pump_on       = lvl[1] || hold_q;
    assign alarm_latched = (state_q == ST_ALARM) || (state_q == ST_ACKED);

endmodule
